// File: rtl/roulette_spin_ctrl.sv
// -----------------------------------------------------------------------------
// roulette_spin_ctrl
//   Wheel-spin sequencer. On an accepted start the LED pocket index steps
//   around a 38-pocket wheel (0..36, 37 = "00"). The step interval stretches
//   over the last DECEL_STEPS steps. When the wheel settles, spin_check is
//   raised for the bet/payout register file and done pulses for one cycle.
//   A free-running 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1) picks the
//   extra step count. It can be loaded from seed for reproducible runs.
//
// Ports
//   clock       in   1   system clock, rising edge
//   reset       in   1   asynchronous, active-low reset
//   start       in   1   spin request, sampled only in IDLE
//   seed_load   in   1   load seed (zero maps to 16'hACE1) into the LFSR
//   seed        in  16   LFSR seed value
//   led_number  out  6   current pocket index 0..37
//   spinning    out  1   high while in SPIN
//   spin_check  out  1   result-valid level, cleared by the next accepted start
//   done        out  1   one-cycle pulse when a spin completes
// -----------------------------------------------------------------------------
module roulette_spin_ctrl #(
    parameter int unsigned CLK_DIV_MIN = 1000,
    parameter int unsigned DIV_STEP    = 250,
    parameter int unsigned BASE_STEPS  = 76,
    parameter int unsigned DECEL_STEPS = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        seed_load,
    input  logic [15:0] seed,
    output logic [5:0]  led_number,
    output logic        spinning,
    output logic        spin_check,
    output logic        done
);

    localparam logic [15:0] LFSR_INIT = 16'hACE1;
    localparam int unsigned SW        = $clog2(BASE_STEPS + 38) + 1;
    localparam logic [15:0] DIV_MIN_SAT =
        (CLK_DIV_MIN > 65535) ? 16'hFFFF : 16'(CLK_DIV_MIN);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SPIN,
        ST_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [15:0]     r_lfsr;
    logic [5:0]      r_led;
    logic [SW-1:0]   r_steps_left;
    logic [15:0]     r_interval;
    logic            r_spinning;
    logic            r_spin_check;
    logic            r_done;

    logic [15:0]     w_seed_eff;
    logic            w_lfsr_fb;
    logic [5:0]      w_r;
    logic [5:0]      w_offset;
    logic [SW-1:0]   w_start_steps;
    logic [SW-1:0]   w_n;
    logic [63:0]     w_n64;
    logic [63:0]     w_reload_wide;
    logic [15:0]     w_reload;
    logic            w_tick;
    logic            w_accept;
    logic            w_step;
    logic            w_finish;

    // ------------------------------------------------------------------
    // LFSR and spin offset
    // ------------------------------------------------------------------
    assign w_seed_eff = (seed == '0) ? LFSR_INIT : seed;
    assign w_lfsr_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

    // A seed loaded in the same cycle as start decides this spin's offset.
    assign w_r           = seed_load ? w_seed_eff[5:0] : r_lfsr[5:0];
    assign w_offset      = (w_r >= 6'd38) ? (w_r - 6'd38) : w_r;
    assign w_start_steps = SW'(BASE_STEPS) + SW'(w_offset);

    // ------------------------------------------------------------------
    // Interval reload: stretch by DIV_STEP per step over the tail of the spin
    // ------------------------------------------------------------------
    assign w_n    = r_steps_left - SW'(1);
    assign w_n64  = 64'(w_n);
    assign w_tick = (r_interval <= 16'd1);

    always_comb begin
        w_reload_wide = 64'(CLK_DIV_MIN);
        if (w_n64 <= 64'(DECEL_STEPS)) begin
            w_reload_wide = 64'(CLK_DIV_MIN)
                          + 64'(DIV_STEP) * (64'(DECEL_STEPS) + 64'd1 - w_n64);
        end
    end

    assign w_reload = (w_reload_wide > 64'h0000_0000_0000_FFFF) ? 16'hFFFF
                                                                : w_reload_wide[15:0];

    // ------------------------------------------------------------------
    // FSM next-state and control strobes
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_SPIN;
                end
            end
            ST_SPIN: begin
                if (w_tick) begin
                    w_step = 1'b1;
                    if (r_steps_left <= SW'(1)) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                w_finish    = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_lfsr       <= LFSR_INIT;
            r_led        <= '0;
            r_steps_left <= '0;
            r_interval   <= '0;
            r_spinning   <= 1'b0;
            r_spin_check <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_spinning <= (w_state_nxt == ST_SPIN);
            r_done     <= w_finish;

            if (seed_load) begin
                r_lfsr <= w_seed_eff;
            end else begin
                r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
            end

            if (w_accept) begin
                r_steps_left <= w_start_steps;
                r_interval   <= DIV_MIN_SAT;
                r_spin_check <= 1'b0;
            end else if (w_step) begin
                r_led        <= (r_led == 6'd37) ? 6'd0 : (r_led + 6'd1);
                r_steps_left <= w_n;
                r_interval   <= w_reload;
            end else if (r_state == ST_SPIN) begin
                r_interval <= r_interval - 16'd1;
            end

            if (w_finish) begin
                r_spin_check <= 1'b1;
            end
        end
    end

    assign led_number = r_led;
    assign spinning   = r_spinning;
    assign spin_check = r_spin_check;
    assign done       = r_done;

endmodule

// File: tb/tb_roulette_spin_ctrl.sv
module tb_roulette_spin_ctrl;

    localparam int unsigned P_DIV   = 4;
    localparam int unsigned P_STEP  = 2;
    localparam int unsigned P_BASE  = 76;
    localparam int unsigned P_DECEL = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic        seed_load;
    logic [15:0] seed;
    logic [5:0]  led_number;
    logic        spinning;
    logic        spin_check;
    logic        done;

    int total = 0;
    int bad   = 0;

    // reference model state
    logic [15:0] m_lfsr;
    int          m_pos;

    roulette_spin_ctrl #(
        .CLK_DIV_MIN (P_DIV),
        .DIV_STEP    (P_STEP),
        .BASE_STEPS  (P_BASE),
        .DECEL_STEPS (P_DECEL)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .seed_load  (seed_load),
        .seed       (seed),
        .led_number (led_number),
        .spinning   (spinning),
        .spin_check (spin_check),
        .done       (done)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] eff_seed(input logic [15:0] s);
        return (s == 16'h0000) ? 16'hACE1 : s;
    endfunction

    // x^16+x^14+x^13+x^11+1, shifting toward bit 0
    function automatic logic [15:0] lfsr_adv(input logic [15:0] x);
        logic b;
        b = x[0] ^ x[2] ^ x[3] ^ x[5];
        return {b, x[15:1]};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // one clock: model follows the edge, outputs sampled at the falling edge
    task automatic cyc();
        @(posedge clock);
        if (!reset)         m_lfsr = 16'hACE1;
        else if (seed_load) m_lfsr = eff_seed(seed);
        else                m_lfsr = lfsr_adv(m_lfsr);
        @(negedge clock);
    endtask

    // mode 0: single start pulse; mode 1: random start/seed_load noise during
    // the spin; mode 2: start held high so the next spin follows immediately
    task automatic run_spin(input bit use_seed, input logic [15:0] sv,
                            input int mode, input bit expect_wrap);
        logic [15:0] src;
        logic [5:0]  prev;
        int r, offset, s_steps, d, t_done, exp_final, last_k;
        int steps, first_step, done_cnt, done_at, spin_hi;
        bit wrapped;

        start     = 1'b1;
        seed_load = use_seed;
        seed      = sv;
        src       = use_seed ? eff_seed(sv) : m_lfsr;
        r         = int'(src[5:0]);
        offset    = (r < 38) ? r : r - 38;
        s_steps   = int'(P_BASE) + offset;
        d         = (s_steps < int'(P_DECEL)) ? s_steps : int'(P_DECEL);
        t_done    = s_steps * int'(P_DIV) + int'(P_STEP) * d * (d + 1) / 2 + 1;
        exp_final = (m_pos + s_steps) % 38;
        last_k    = (mode == 2) ? t_done : t_done + 1;

        check("start_pos", led_number, m_pos);
        cyc();
        seed_load = 1'b0;
        if (mode != 2) start = 1'b0;
        check("e0_spinning", spinning, 1);
        check("e0_spin_check", spin_check, 0);
        check("e0_done", done, 0);

        prev = led_number;
        steps = 0; first_step = -1; done_cnt = 0; done_at = -1; spin_hi = 0; wrapped = 0;
        for (int k = 1; k <= last_k; k++) begin
            if (mode == 1) begin
                if (k <= t_done - 3) begin
                    start     = 1'($urandom_range(0, 1));
                    seed_load = ($urandom_range(0, 7) == 0);
                    seed      = 16'($urandom);
                end else begin
                    start     = 1'b0;
                    seed_load = 1'b0;
                end
            end
            cyc();
            if (led_number !== prev) begin
                steps++;
                if (first_step < 0) first_step = k;
                if (prev == 6'd37 && led_number == 6'd0) wrapped = 1;
            end
            prev = led_number;
            if (spinning) spin_hi++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (k == t_done - 1) check("spin_check_before_done", spin_check, 0);
            if (k == t_done)     check("spin_check_at_done", spin_check, 1);
        end

        check("step_count", steps, s_steps);
        check("first_step_cycle", first_step, P_DIV);
        check("done_cycle", done_at, t_done);
        check("done_pulses", done_cnt, 1);
        check("spinning_cycles", spin_hi, t_done - 2);
        check("final_led", led_number, exp_final);
        if (expect_wrap) check("wrap_seen", wrapped, 1);
        if (mode != 2) begin
            check("spin_check_held", spin_check, 1);
            check("done_low_after", done, 0);
        end
        m_pos = exp_final;
    endtask

    initial begin
        int done_seen;
        reset     = 1'b0;
        start     = 1'b0;
        seed_load = 1'b0;
        seed      = 16'h0000;
        m_lfsr    = 16'hACE1;
        m_pos     = 0;

        #1;
        check("rst_led", led_number, 0);
        check("rst_spinning", spinning, 0);
        check("rst_spin_check", spin_check, 0);
        check("rst_done", done, 0);
        repeat (3) cyc();
        reset = 1'b1;
        cyc();

        // reset mid-spin
        start = 1'b1;
        cyc();
        start = 1'b0;
        done_seen = 0;
        repeat (50) begin
            cyc();
            if (done) done_seen++;
        end
        check("pre_reset_spinning", spinning, 1);
        #2 reset = 1'b0;
        #1;
        check("abort_led", led_number, 0);
        check("abort_spinning", spinning, 0);
        check("abort_spin_check", spin_check, 0);
        check("abort_done", done, 0);
        check("abort_lfsr", dut.r_lfsr, 16'hACE1);
        @(negedge clock);
        m_lfsr = 16'hACE1;
        repeat (3) begin
            cyc();
            if (done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        reset = 1'b1;
        m_pos = 0;
        cyc();

        // seeded spin: seed 5 -> 81 steps, lands on 5
        run_spin(1'b1, 16'h0005, 0, 1'b0);
        check("seeded_final", m_pos, 5);
        // zero seed from 5 -> offset 33 (ACE1), lands on 0
        run_spin(1'b1, 16'h0000, 0, 1'b1);
        // 0x3F reduces to 25
        run_spin(1'b1, 16'h003F, 0, 1'b0);
        // starts and seed loads ignored while spinning
        run_spin(1'b0, 16'h0000, 1, 1'b0);
        // back-to-back with start held
        run_spin(1'b0, 16'h0000, 2, 1'b0);
        run_spin(1'b0, 16'h0000, 0, 1'b0);
        // random spins
        repeat (3) run_spin(1'($urandom_range(0, 1)), 16'($urandom), 1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
